// File: rtl/input_vc_requester.sv
// Input-port requester: round-robin picks a VC with a head packet, requests
// its destination output/VC, then streams the packet once the arbiter grants.
//
// Ports:
//   clk, resetn                : clock, synchronous active-low reset
//   head_valid   [V]           : per-VC head word available
//   head_dest    [V*OW]        : per-VC destination output (VC0 in LSBs)
//   head_vc_dest [V*VW]        : per-VC destination output VC
//   rd_data      [V*data_w]    : per-VC head word
//   rd_last      [V]           : per-VC head word ends the packet
//   vc_rd_en     [V]           : pop strobe to the VC buffers
//   selected_request[o][k]     : request for output o, output VC k
//   output_dest, output_vc_dest: latched destination of the current packet
//   grant_from_output_arbiter  : grant per output
//   out_data, out_valid        : flit to the crossbar
//   out_ready                  : crossbar accepts the flit
//   last                       : handshake of the final packet word
module input_vc_requester #(
   parameter  int vc_num     = 3,
   parameter  int prio_num   = 2,
   parameter  int output_num = 8,
   parameter  int data_w     = 64,
   localparam int V          = vc_num * prio_num,
   localparam int OW         = $clog2(output_num),
   localparam int VW         = $clog2(V)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [V-1:0]      head_valid,
   input  logic [V*OW-1:0]   head_dest,
   input  logic [V*VW-1:0]   head_vc_dest,
   input  logic [V*data_w-1:0] rd_data,
   input  logic [V-1:0]      rd_last,
   output logic [V-1:0]      vc_rd_en,
   output logic [V-1:0]      selected_request [output_num-1:0],
   output logic [OW-1:0]     output_dest,
   output logic [VW-1:0]     output_vc_dest,
   input  logic [output_num-1:0] grant_from_output_arbiter,
   output logic [data_w-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              last
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      XFER
   } state_t;

   state_t state;
   state_t state_n;

   logic [VW-1:0] rr_ptr;
   logic [VW-1:0] rr_ptr_n;
   logic [VW-1:0] sel_vc;
   logic [VW-1:0] sel_vc_n;
   logic [OW-1:0] output_dest_n;
   logic [VW-1:0] output_vc_dest_n;

   logic [OW-1:0]     dest_arr [V];
   logic [VW-1:0]     vcd_arr  [V];
   logic [data_w-1:0] data_arr [V];

   logic          pick_found;
   logic [VW-1:0] pick_vc;
   logic [VW:0]   scan;
   logic          granted;
   logic          hs;

   always_comb begin
      for (int k = 0; k < V; k++) begin
         dest_arr[k] = head_dest[k*OW +: OW];
         vcd_arr[k]  = head_vc_dest[k*VW +: VW];
         data_arr[k] = rd_data[k*data_w +: data_w];
      end
   end

   // Scan rr_ptr+1 .. rr_ptr+V with wrap; V need not be a power of two,
   // so the wrap is an explicit subtract on a one-bit-wider index.
   always_comb begin
      pick_found = 1'b0;
      pick_vc    = '0;
      scan       = '0;
      for (int i = 1; i <= V; i++) begin
         scan = {1'b0, rr_ptr} + (VW+1)'(i);
         if (scan >= (VW+1)'(V)) begin
            scan = scan - (VW+1)'(V);
         end
         if (!pick_found && head_valid[scan[VW-1:0]]) begin
            pick_found = 1'b1;
            pick_vc    = scan[VW-1:0];
         end
      end
   end

   assign granted = grant_from_output_arbiter[output_dest];

   always_comb begin
      state_n          = state;
      rr_ptr_n         = rr_ptr;
      sel_vc_n         = sel_vc;
      output_dest_n    = output_dest;
      output_vc_dest_n = output_vc_dest;
      out_valid        = 1'b0;
      out_data         = '0;
      vc_rd_en         = '0;
      last             = 1'b0;
      hs               = 1'b0;
      for (int o = 0; o < output_num; o++) begin
         selected_request[o] = '0;
      end
      unique case (state)
         IDLE: begin
            if (pick_found) begin
               sel_vc_n         = pick_vc;
               output_dest_n    = dest_arr[pick_vc];
               output_vc_dest_n = vcd_arr[pick_vc];
               state_n          = REQ;
            end
         end
         REQ: begin
            selected_request[output_dest][output_vc_dest] = 1'b1;
            if (granted) begin
               state_n = XFER;
            end
         end
         XFER: begin
            // Request is held through the packet so the arbiter keeps
            // the output locked; a dropped grant just stalls the stream.
            selected_request[output_dest][output_vc_dest] = 1'b1;
            out_valid        = head_valid[sel_vc] & granted;
            out_data         = data_arr[sel_vc];
            hs               = out_valid & out_ready;
            vc_rd_en[sel_vc] = hs;
            last             = hs & rd_last[sel_vc];
            if (last) begin
               state_n  = IDLE;
               rr_ptr_n = sel_vc;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state          <= IDLE;
         rr_ptr         <= VW'(V-1);
         sel_vc         <= '0;
         output_dest    <= '0;
         output_vc_dest <= '0;
      end else begin
         state          <= state_n;
         rr_ptr         <= rr_ptr_n;
         sel_vc         <= sel_vc_n;
         output_dest    <= output_dest_n;
         output_vc_dest <= output_vc_dest_n;
      end
   end

endmodule

// File: tb/tb_input_vc_requester.sv
// Scoreboard bench for input_vc_requester: VC buffer and arbiter models
// drive the DUT; a round-robin packet model predicts requests and flits.
module tb_input_vc_requester;

   localparam int V  = 6;
   localparam int NO = 8;
   localparam int OW = 3;
   localparam int VW = 3;
   localparam int DW = 64;

   logic              clk = 1'b0;
   logic              resetn;
   logic [V-1:0]      head_valid;
   logic [V*OW-1:0]   head_dest;
   logic [V*VW-1:0]   head_vc_dest;
   logic [V*DW-1:0]   rd_data;
   logic [V-1:0]      rd_last;
   logic [V-1:0]      vc_rd_en;
   logic [V-1:0]      selected_request [NO-1:0];
   logic [OW-1:0]     output_dest;
   logic [VW-1:0]     output_vc_dest;
   logic [NO-1:0]     grant;
   logic [DW-1:0]     out_data;
   logic              out_valid;
   logic              out_ready;
   logic              last;

   always #5 clk = ~clk;

   input_vc_requester #(
      .vc_num(3), .prio_num(2), .output_num(NO), .data_w(DW)
   ) dut (
      .clk(clk),
      .resetn(resetn),
      .head_valid(head_valid),
      .head_dest(head_dest),
      .head_vc_dest(head_vc_dest),
      .rd_data(rd_data),
      .rd_last(rd_last),
      .vc_rd_en(vc_rd_en),
      .selected_request(selected_request),
      .output_dest(output_dest),
      .output_vc_dest(output_vc_dest),
      .grant_from_output_arbiter(grant),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .last(last)
   );

   typedef struct {
      logic [DW-1:0] d;
      bit            l;
      logic [OW-1:0] dest;
      logic [VW-1:0] vcd;
   } word_t;
   typedef struct { int dest; int vcd; int n; } pkt_t;
   typedef struct { int vc; int dest; int vcd; int cyc; } req_t;
   typedef struct { logic [DW-1:0] d; bit l; int vc; int cyc; } flit_t;

   word_t         bq [V][$];
   pkt_t          mq [V][$];
   logic [DW-1:0] mw [V][$];
   bit            mid [V];
   req_t          exp_req [$];
   flit_t         exp_flit [$];

   int cyc = 0;
   int n_chk = 0;
   int n_fail = 0;
   int model_ptr = V-1;
   bit rnd = 0;
   bit drop_en = 0;
   bit rdy_rand = 0;
   int force_delay = 0;
   bit arb_active = 0;
   int arb_out = 0;
   int wait_cnt = 0;
   int drop_cnt = 0;
   bit mon_en = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string name, logic [63:0] act,
                               logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endfunction

   function automatic void fail(string name);
      n_chk++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endfunction

   task automatic add_pkt(int vc, int dest, int vcd, int n);
      pkt_t p;
      word_t w;
      logic [DW-1:0] d;
      p.dest = dest;
      p.vcd  = vcd;
      p.n    = n;
      mq[vc].push_back(p);
      for (int i = 0; i < n; i++) begin
         d = {$urandom, $urandom};
         mw[vc].push_back(d);
         w.d    = d;
         w.l    = (i == n-1);
         w.dest = OW'(dest);
         w.vcd  = VW'(vcd);
         bq[vc].push_back(w);
      end
   endtask

   function automatic bit mq_any();
      for (int k = 0; k < V; k++)
         if (mq[k].size() > 0) return 1'b1;
      return 1'b0;
   endfunction

   // Round robin over whole packets: next non-empty VC after the last served.
   // c0 >= 0 gives exact cycles for a lone packet loaded in cycle c0.
   task automatic run_model(int c0, int gd);
      int k;
      pkt_t p;
      req_t r;
      flit_t f;
      while (mq_any()) begin
         k = model_ptr;
         do k = (k + 1) % V; while (mq[k].size() == 0);
         p = mq[k].pop_front();
         model_ptr = k;
         r.vc   = k;
         r.dest = p.dest;
         r.vcd  = p.vcd;
         r.cyc  = (c0 >= 0) ? c0 + 1 : -1;
         exp_req.push_back(r);
         for (int i = 0; i < p.n; i++) begin
            f.d   = mw[k].pop_front();
            f.l   = (i == p.n-1);
            f.vc  = k;
            f.cyc = (c0 >= 0) ? c0 + 2 + gd + i : -1;
            exp_flit.push_back(f);
         end
      end
   endtask

   task automatic drive_inputs();
      word_t w;
      for (int k = 0; k < V; k++) begin
         head_valid[k]           = 1'b0;
         head_dest[k*OW +: OW]   = '0;
         head_vc_dest[k*VW +: VW] = '0;
         rd_data[k*DW +: DW]     = '0;
         rd_last[k]              = 1'b0;
         if (bq[k].size() > 0) begin
            w = bq[k][0];
            head_valid[k]            = 1'b1;
            head_dest[k*OW +: OW]    = w.dest;
            head_vc_dest[k*VW +: VW] = w.vcd;
            rd_data[k*DW +: DW]      = w.d;
            rd_last[k]               = w.l;
            if (rnd && mid[k]) begin
               if ($urandom_range(0, 4) == 0) head_valid[k] = 1'b0;
               head_dest[k*OW +: OW]    = OW'($urandom);
               head_vc_dest[k*VW +: VW] = VW'($urandom);
            end
         end
      end
   endtask

   task automatic step();
      logic [V-1:0] pops;
      word_t w;
      int o;
      @(negedge clk);
      pops = vc_rd_en;
      @(posedge clk);
      #1;
      for (int k = 0; k < V; k++) begin
         if (pops[k] && bq[k].size() > 0) begin
            w = bq[k].pop_front();
            mid[k] = !w.l;
         end
      end
      o = -1;
      for (int oo = 0; oo < NO; oo++)
         if (selected_request[oo] != '0) o = oo;
      if (o < 0) begin
         arb_active = 1'b0;
      end else if (!arb_active || o != arb_out) begin
         arb_active = 1'b1;
         arb_out    = o;
         wait_cnt   = (force_delay >= 0) ? force_delay
                                         : int'($urandom_range(0, 3));
         drop_cnt   = 0;
      end
      grant = rnd ? NO'($urandom) : '0;
      if (arb_active) begin
         if (wait_cnt > 0) begin
            wait_cnt--;
            grant[arb_out] = 1'b0;
         end else if (drop_cnt > 0) begin
            drop_cnt--;
            grant[arb_out] = 1'b0;
         end else begin
            grant[arb_out] = 1'b1;
            if (drop_en && $urandom_range(0, 2) == 0)
               drop_cnt = int'($urandom_range(1, 2));
         end
      end
      out_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      drive_inputs();
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      step();
      resetn = 1'b1;
      for (int k = 0; k < V; k++) begin
         bq[k].delete();
         mq[k].delete();
         mw[k].delete();
         mid[k] = 1'b0;
      end
      exp_req.delete();
      exp_flit.delete();
      model_ptr  = V-1;
      arb_active = 1'b0;
      grant      = '0;
      drive_inputs();
   endtask

   function automatic bit bufs_empty();
      for (int k = 0; k < V; k++)
         if (bq[k].size() > 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit req_now();
      for (int o = 0; o < NO; o++)
         if (selected_request[o] != '0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic drain();
      int t;
      for (t = 0; t < 3000; t++) begin
         step();
         if (bufs_empty() && exp_flit.size() == 0 && !req_now()) break;
      end
      if (t >= 3000) begin
         fail("drain_timeout");
         do_reset();
      end
      chk("leftover_requests", 64'(exp_req.size()), 64'd0);
      step();
   endtask

   // Monitor: requests and flits are compared against the model queues.
   bit req_prev = 1'b0;
   req_t cur;
   logic [V*NO-1:0] cur_flat;

   always @(negedge clk) begin
      logic [V*NO-1:0] flat;
      logic [V-1:0] en_exp;
      req_t r;
      flit_t f;
      if (mon_en) begin
         flat = '0;
         for (int o = 0; o < NO; o++) flat[o*V +: V] = selected_request[o];
         chk("req_onehot0", 64'($countones(flat) <= 1), 64'd1);
         if (flat != '0 && !req_prev) begin
            if (exp_req.size() == 0) begin
               fail("unexpected_request");
            end else begin
               r = exp_req.pop_front();
               cur = r;
               cur_flat = '0;
               cur_flat[r.dest*V + r.vcd] = 1'b1;
               chk("req_bits", 64'(flat), 64'(cur_flat));
               chk("output_dest", 64'(output_dest), 64'(r.dest));
               chk("output_vc_dest", 64'(output_vc_dest), 64'(r.vcd));
               if (r.cyc >= 0) chk("req_cycle", 64'(cyc), 64'(r.cyc));
            end
         end else if (flat != '0) begin
            chk("req_held", 64'(flat), 64'(cur_flat));
         end
         req_prev = (flat != '0);
         if (out_valid && out_ready) begin
            if (exp_flit.size() == 0) begin
               fail("unexpected_flit");
            end else begin
               f = exp_flit.pop_front();
               en_exp = '0;
               en_exp[f.vc] = 1'b1;
               chk("out_data", out_data, f.d);
               chk("last", 64'(last), 64'(f.l));
               chk("vc_rd_en", 64'(vc_rd_en), 64'(en_exp));
               if (f.cyc >= 0) chk("flit_cycle", 64'(cyc), 64'(f.cyc));
            end
         end else begin
            chk("no_pop", 64'(vc_rd_en), 64'd0);
            chk("no_last", 64'(last), 64'd0);
         end
         if (out_valid) begin
            chk("valid_needs_grant", 64'(grant[cur.dest]), 64'd1);
            chk("valid_needs_head", 64'(head_valid[cur.vc]), 64'd1);
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [V*NO-1:0] flat;
      int n;
      resetn    = 1'b0;
      grant     = '0;
      out_ready = 1'b0;
      drive_inputs();
      repeat (3) @(posedge clk);
      #1;
      flat = '0;
      for (int o = 0; o < NO; o++) flat[o*V +: V] = selected_request[o];
      chk("rst_request", 64'(flat), 64'd0);
      chk("rst_output_dest", 64'(output_dest), 64'd0);
      chk("rst_output_vc_dest", 64'(output_vc_dest), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_vc_rd_en", 64'(vc_rd_en), 64'd0);
      chk("rst_last", 64'(last), 64'd0);
      resetn = 1'b1;
      mon_en = 1'b1;
      out_ready = 1'b1;

      force_delay = 1;
      add_pkt(2, 5, 3, 3);
      run_model(cyc, 1);
      drive_inputs();
      drain();

      force_delay = 0;
      add_pkt(4, 1, 0, 2);
      run_model(cyc, 0);
      drive_inputs();
      drain();

      force_delay = 3;
      add_pkt(0, 7, 5, 2);
      run_model(cyc, 3);
      drive_inputs();
      drain();

      force_delay = -1;
      drop_en  = 1'b1;
      rdy_rand = 1'b1;
      add_pkt(1, 3, 2, 6);
      run_model(-1, 0);
      drive_inputs();
      drain();
      drop_en  = 1'b0;
      rdy_rand = 1'b0;

      force_delay = 0;
      add_pkt(3, 6, 4, 4);
      run_model(-1, 0);
      drive_inputs();
      for (int t = 0; t < 200 && bq[3].size() > 2; t++) step();
      chk("words_before_reset", 64'(bq[3].size()), 64'd2);
      do_reset();
      flat = '0;
      for (int o = 0; o < NO; o++) flat[o*V +: V] = selected_request[o];
      chk("midrst_request", 64'(flat), 64'd0);
      chk("midrst_out_valid", 64'(out_valid), 64'd0);

      for (int k = 0; k < V; k++) add_pkt(k, k, (k + 1) % V, 1);
      add_pkt(0, 7, 2, 1);
      run_model(-1, 0);
      drive_inputs();
      drain();

      rnd = 1'b1;
      drop_en = 1'b1;
      rdy_rand = 1'b1;
      force_delay = -1;
      repeat (40) begin
         for (int k = 0; k < V; k++) begin
            n = int'($urandom_range(0, 2));
            for (int j = 0; j < n; j++)
               add_pkt(k, int'($urandom_range(0, NO-1)),
                       int'($urandom_range(0, V-1)),
                       int'($urandom_range(1, 6)));
         end
         run_model(-1, 0);
         drive_inputs();
         drain();
      end

      chk("final_flits_left", 64'(exp_flit.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/input_vc_requester.md
Name: input_vc_requester

Overview:
- Input-port side of the output-arbiter grant interface: the requester that the output arbiter grants.
- Picks one input VC with a head-of-line packet using round-robin, and raises a one-hot request toward that packet's destination output and output VC.
- Waits for grant_from_output_arbiter on that output, streams the packet from the selected VC buffer to the crossbar, and signals last on the final word.
- One instance per switch input port.

Parameters:
- vc_num, 3, VCs per priority level.
- prio_num, 2, priority levels; V = vc_num*prio_num total VCs.
- output_num, 8, switch outputs; OW = $clog2(output_num).
- data_w, 64, flit width.
- VW = $clog2(V) (derived).

Ports:
- clk  input  1  clock.
- resetn  input  1  synchronous, active-low reset.
- head_valid  input  V  per input VC: packet head word is available.
- head_dest  input  V*OW  per-VC destination output, packed, VC0 in LSBs.
- head_vc_dest  input  V*VW  per-VC destination output VC, packed.
- rd_data  input  V*data_w  per-VC head word, packed.
- rd_last  input  V  per-VC head word is the packet's last word.
- vc_rd_en  output  V  pop strobe to the VC buffers; one-hot or zero.
- selected_request  output  V x output_num  unpacked [output_num-1:0] of V bits; bit [o][k] = request for output o, output VC k.
- output_dest  output  OW  registered destination of the current request.
- output_vc_dest  output  VW  registered destination output VC.
- grant_from_output_arbiter  input  output_num  grant per output.
- out_data  output  data_w  flit to the crossbar.
- out_valid  output  1  flit valid.
- out_ready  input  1  crossbar accepts.
- last  output  1  final-word handshake of the packet.

Behaviour:
- States: IDLE, REQ, XFER. Reset takes effect on the next clk edge and gives:
  - state=IDLE, rr_ptr=V-1, all outputs 0.
  - selected_request all zero, output_dest=0, output_vc_dest=0.
- IDLE:
  - If any head_valid bit is set, pick the first set bit searching from rr_ptr+1 upward with wrap mod V.
  - Latch sel_vc, output_dest and output_vc_dest from that VC's fields, then go to REQ.
  - If no head_valid bit is set, stay in IDLE.
  - Request latency: head_valid at edge t gives the request visible after edge t+1.
- REQ:
  - selected_request[output_dest][output_vc_dest]=1; every other bit is 0.
  - If grant_from_output_arbiter[output_dest]=1 in the same cycle (a zero-cycle grant is legal), go to XFER next edge; otherwise stay in REQ indefinitely.
  - Grants on other outputs are ignored.
- XFER:
  - The request stays asserted.
  - out_valid = head_valid[sel_vc] & grant_from_output_arbiter[output_dest].
  - out_data = rd_data[sel_vc].
  - vc_rd_en[sel_vc] = out_valid & out_ready.
  - last = out_valid & out_ready & rd_last[sel_vc].
- Packet end: on the last handshake, go to IDLE next edge, set rr_ptr=sel_vc, and clear selected_request on that edge.
- Grant drop mid-packet: if grant falls during XFER, stall with out_valid=0 and no pop; stay in XFER and keep requesting.
- Stalls: head_valid[sel_vc]=0 mid-packet gives a bubble with out_valid=0; state is held.
- Outputs outside XFER: out_valid, vc_rd_en and last are 0 in IDLE and REQ.
- Single-word packet: rd_last=1 on the first XFER handshake gives last in that cycle, then IDLE.
- Head changes during REQ/XFER: changes to head_dest or head_vc_dest of sel_vc are ignored, because the values were latched in IDLE.
- Reset mid-packet: everything returns to its reset value on the next edge. No partial-packet recovery; the buffers are reset together with this block.
- Minimum gap between packets: one IDLE cycle.
- Invariant: at most one bit of selected_request is set across all outputs.

Test Plan:
- Basic request:
  - Stimulus: reset, then head_valid=6'b000100 with VC2 dest=5, vc_dest=3.
  - Required: REQ one cycle later with selected_request[5]=6'b001000, output_dest=5, output_vc_dest=3.
  - Then grant[5]=1 for 3-word packet, out_ready=1 → 3 consecutive out_valid cycles, vc_rd_en=6'b000100 each, last on 3rd.
- Zero-cycle grant:
  - Stimulus: grant[dest] already high when REQ is entered.
  - Required: XFER next edge; first flit valid 2 cycles after the head_valid cycle.
- Delayed grant:
  - Stimulus: grant arrives 3 cycles after the request (arbiter delay model).
  - Required: request held steady for 3 cycles, no out_valid; transfer starts the cycle after the grant.
- Round-robin:
  - Stimulus: all 6 head_valid set, 1-word packets.
  - Required: VCs served in order 0,1,2,3,4,5,0; after serving VC5, VC0 is next.
- Backpressure and grant drop:
  - Stimulus: out_ready toggles 1,0,1; grant dropped for 2 cycles mid-packet.
  - Required: no pop while out_ready=0 or grant=0; word order preserved; last asserted once.
- Reset mid-XFER:
  - Stimulus: resetn=0 for 1 cycle after word 2 of 4.
  - Required: next cycle IDLE, selected_request=0, out_valid=0; next selection starts from VC0.
